// File: rtl/mem_arbiter_pkg.sv
// Types shared by the instruction/data memory arbiter and its grant logic.
package mem_arbiter_pkg;

    typedef logic [1:0] lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } lc3b_arb_state;

    typedef enum logic {
        ARB_INSN = 1'b0,
        ARB_DATA = 1'b1
    } lc3b_arb_port;

endpackage

// File: rtl/mem_arbiter_grant.sv
// Combinational tie-break between the instruction and data ports.
module arb_grant
    import mem_arbiter_pkg::*;
#(
    parameter int FAIR = 1
)
(
    input  logic pend_i,
    input  logic pend_d,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    // On a tie, round-robin hands the bus to whichever port did not have it last.
    always_comb begin
        grant_valid = pend_i | pend_d;
        grant       = ARB_INSN;
        if (pend_i && pend_d) begin
            if ((FAIR != 0) && (last_grant == ARB_DATA)) begin
                grant = ARB_INSN;
            end else begin
                grant = ARB_DATA;
            end
        end else if (pend_d) begin
            grant = ARB_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises the instruction-fetch and data memory ports onto one pmem initiator,
// one registered transaction at a time, with a one-cycle response pulse per port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int FAIR  = 1,
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,

    input  logic             mem_read_0,
    input  logic [WIDTH-1:0] mem_address_0,
    output logic [WIDTH-1:0] mem_rdata_0,
    output logic             mem_resp_0,

    input  logic             mem_read_1,
    input  logic             mem_write_1,
    input  logic [1:0]       mem_byte_enable_1,
    input  logic [WIDTH-1:0] mem_address_1,
    input  logic [WIDTH-1:0] mem_wdata_1,
    output logic [WIDTH-1:0] mem_rdata_1,
    output logic             mem_resp_1,

    output logic             pmem_read,
    output logic             pmem_write,
    output logic [1:0]       pmem_byte_enable,
    output logic [WIDTH-1:0] pmem_address,
    output logic [WIDTH-1:0] pmem_wdata,
    input  logic [WIDTH-1:0] pmem_rdata,
    input  logic             pmem_resp
);

    // Memory is word addressed on the downstream side, so bit 0 is always cleared.
    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

    lc3b_arb_state state;
    lc3b_arb_state state_next;
    lc3b_arb_port  last_grant;
    lc3b_arb_port  last_grant_next;

    logic          pend_i;
    logic          pend_d;
    logic          grant_valid;
    logic          grant;

    logic          load_i;
    logic          load_d;
    logic          drop_pmem;
    logic          resp_0_next;
    logic          resp_1_next;
    logic          capture_0;
    logic          capture_1;
    lc3b_mem_wmask data_mask;

    assign pend_i    = mem_read_0;
    assign pend_d    = mem_read_1 | mem_write_1;
    assign data_mask = mem_byte_enable_1;

    arb_grant #(
        .FAIR(FAIR)
    ) u_grant (
        .pend_i      (pend_i),
        .pend_d      (pend_d),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ARB_INSN;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    if (grant == ARB_DATA) begin
                        state_next      = BUSY_D;
                        last_grant_next = ARB_DATA;
                    end else begin
                        state_next      = BUSY_I;
                        last_grant_next = ARB_INSN;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (pmem_resp) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RESP deliberately produces nothing: it is the bubble that lets a requester
    // drop its request before the arbiter looks at it again.
    always_comb begin
        load_i      = 1'b0;
        load_d      = 1'b0;
        drop_pmem   = 1'b0;
        resp_0_next = 1'b0;
        resp_1_next = 1'b0;
        capture_0   = 1'b0;
        capture_1   = 1'b0;
        unique case (state)
            IDLE: begin
                load_i = grant_valid && (grant == ARB_INSN);
                load_d = grant_valid && (grant == ARB_DATA);
            end
            BUSY_I: begin
                if (pmem_resp) begin
                    resp_0_next = 1'b1;
                    capture_0   = 1'b1;
                    drop_pmem   = 1'b1;
                end
            end
            BUSY_D: begin
                if (pmem_resp) begin
                    resp_1_next = 1'b1;
                    capture_1   = pmem_read;
                    drop_pmem   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // A data request with both read and write set is issued as a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_byte_enable <= '0;
            pmem_address     <= '0;
            pmem_wdata       <= '0;
            mem_resp_0       <= 1'b0;
            mem_resp_1       <= 1'b0;
            mem_rdata_0      <= '0;
            mem_rdata_1      <= '0;
        end else begin
            mem_resp_0 <= resp_0_next;
            mem_resp_1 <= resp_1_next;

            if (load_i) begin
                pmem_read        <= 1'b1;
                pmem_write       <= 1'b0;
                pmem_byte_enable <= '0;
                pmem_address     <= mem_address_0 & ALIGN_MASK;
                pmem_wdata       <= '0;
            end else if (load_d) begin
                pmem_read        <= mem_read_1 & ~mem_write_1;
                pmem_write       <= mem_write_1;
                pmem_byte_enable <= data_mask;
                pmem_address     <= mem_address_1 & ALIGN_MASK;
                pmem_wdata       <= mem_wdata_1;
            end else if (drop_pmem) begin
                pmem_read  <= 1'b0;
                pmem_write <= 1'b0;
            end

            if (capture_0) begin
                mem_rdata_0 <= pmem_rdata;
            end
            if (capture_1) begin
                mem_rdata_1 <= pmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios, a fixed-priority twin
// for tie-break comparison, and a randomized two-port run against a pmem model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        mem_read_0;
    logic [15:0] mem_address_0;
    logic [15:0] mem_rdata_0;
    logic        mem_resp_0;
    logic        mem_read_1;
    logic        mem_write_1;
    logic [1:0]  mem_byte_enable_1;
    logic [15:0] mem_address_1;
    logic [15:0] mem_wdata_1;
    logic [15:0] mem_rdata_1;
    logic        mem_resp_1;
    logic        pmem_read;
    logic        pmem_write;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    logic [15:0] f_rdata_0;
    logic        f_resp_0;
    logic [15:0] f_rdata_1;
    logic        f_resp_1;
    logic        f_pmem_read;
    logic        f_pmem_write;
    logic [1:0]  f_pmem_byte_enable;
    logic [15:0] f_pmem_address;
    logic [15:0] f_pmem_wdata;

    int          vectors     = 0;
    int          miscompares = 0;
    int          resp_lat    = 1;
    bit          lat_random  = 1'b0;
    bit          auto_en     = 1'b1;
    bit          stress_mode = 1'b0;
    int          txn_count   = 0;
    int          last_port   = 0;
    logic [15:0] cur_addr0;
    logic [15:0] cur_addr1;
    logic [15:0] cur_wdata1;
    logic        cur_write1;
    logic [1:0]  cur_be1;
    logic [15:0] model_rdata1;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] preload [int];

    mem_arbiter #(.FAIR(1), .WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .mem_read_0(mem_read_0), .mem_address_0(mem_address_0),
        .mem_rdata_0(mem_rdata_0), .mem_resp_0(mem_resp_0),
        .mem_read_1(mem_read_1), .mem_write_1(mem_write_1),
        .mem_byte_enable_1(mem_byte_enable_1), .mem_address_1(mem_address_1),
        .mem_wdata_1(mem_wdata_1), .mem_rdata_1(mem_rdata_1), .mem_resp_1(mem_resp_1),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_byte_enable(pmem_byte_enable), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    // Fixed-priority twin sees the same requests and pmem responses; grant timing
    // is identical to the fair instance, only the tie winner differs.
    mem_arbiter #(.FAIR(0), .WIDTH(16)) dut_fixed (
        .clk(clk), .rst(rst),
        .mem_read_0(mem_read_0), .mem_address_0(mem_address_0),
        .mem_rdata_0(f_rdata_0), .mem_resp_0(f_resp_0),
        .mem_read_1(mem_read_1), .mem_write_1(mem_write_1),
        .mem_byte_enable_1(mem_byte_enable_1), .mem_address_1(mem_address_1),
        .mem_wdata_1(mem_wdata_1), .mem_rdata_1(f_rdata_1), .mem_resp_1(f_resp_1),
        .pmem_read(f_pmem_read), .pmem_write(f_pmem_write),
        .pmem_byte_enable(f_pmem_byte_enable), .pmem_address(f_pmem_address),
        .pmem_wdata(f_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_fn(input logic [15:0] a);
        if (preload.exists(int'(a))) begin
            return preload[int'(a)];
        end
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_rdata1 = '0;
        last_port = 0;
        tick();
    endtask

    // Behavioural pmem: answers each transaction after a latency, checks the request
    // stays put while outstanding, and in stress mode checks fields and fairness.
    task automatic responder();
        bit          tie;
        int          lat;
        int          port;
        logic [15:0] a;
        logic [15:0] wd;
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        forever begin
            @(posedge clk);
            tie = mem_read_0 && (mem_read_1 || mem_write_1);
            #2;
            if (auto_en && (pmem_read || pmem_write)) begin
                txn_count++;
                a = pmem_address; wd = pmem_wdata; rd = pmem_read; wr = pmem_write; be = pmem_byte_enable;
                port = int'(a[15]);
                vectors++;
                if (rd && wr) begin
                    miscompares++;
                    $display("[TB] FAIL rw_overlap: read=%b write=%b, expected never both 1", rd, wr);
                end
                if (stress_mode) begin
                    vectors++;
                    if (port == 0) begin
                        if (a !== cur_addr0 || rd !== 1'b1 || wr !== 1'b0) begin
                            miscompares++;
                            $display("[TB] FAIL stress_fields_0: addr=%h rd=%b wr=%b, expected addr=%h rd=1 wr=0", a, rd, wr, cur_addr0);
                        end
                    end else if (a !== cur_addr1 || wr !== cur_write1 || rd !== !cur_write1 ||
                                 (cur_write1 && (wd !== cur_wdata1 || be !== cur_be1))) begin
                        miscompares++;
                        $display("[TB] FAIL stress_fields_1: addr=%h wr=%b wd=%h be=%b, expected addr=%h wr=%b wd=%h be=%b",
                                 a, wr, wd, be, cur_addr1, cur_write1, cur_wdata1, cur_be1);
                    end
                    if (tie) begin
                        vectors++;
                        if (port == last_port) begin
                            miscompares++;
                            $display("[TB] FAIL tie_run: port %0d granted twice in a row under a tie, expected port %0d", port, 1 - last_port);
                        end
                    end
                end
                last_port = port;
                lat = lat_random ? int'($urandom_range(1, 8)) : resp_lat;
                for (int c = 1; c < lat; c++) begin
                    @(posedge clk);
                    #2;
                    vectors++;
                    if ({pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata} !== {rd, wr, be, a, wd}) begin
                        miscompares++;
                        $display("[TB] FAIL busy_stable: addr=%h rd=%b wr=%b, expected addr=%h rd=%b wr=%b held",
                                 pmem_address, pmem_read, pmem_write, a, rd, wr);
                    end
                end
                pmem_rdata = rd_fn(a);
                pmem_resp = 1'b1;
                @(posedge clk);
                #2;
                pmem_resp = 1'b0;
                pmem_rdata = 16'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #2;
        vectors++;
        if ({pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata} !== 36'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_pmem: rd=%b wr=%b addr=%h, expected all zero", pmem_read, pmem_write, pmem_address);
        end
        vectors++;
        if ({mem_resp_0, mem_resp_1} !== 2'b00 || mem_rdata_0 !== 16'h0 || mem_rdata_1 !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_ports: resp=%b%b rdata0=%h rdata1=%h, expected zeros", mem_resp_0, mem_resp_1, mem_rdata_0, mem_rdata_1);
        end
        tick();
        #2 rst = 1'b0;
        model_rdata1 = '0;
        tick();
        vectors++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: rd=%b wr=%b, expected 0 0", pmem_read, pmem_write);
        end
    endtask

    task automatic test_single_iread();
        int          cyc = 0;
        bit          seen = 1'b0;
        bit          stray = 1'b0;
        logic [15:0] exp;
        preload[16'h0060] = 16'h1234;
        resp_lat = 3;
        mem_read_0 = 1'b1;
        mem_address_0 = 16'h0061;
        q0.push_back(16'h1234);
        tick();
        vectors++;
        if (pmem_address !== 16'h0060 || pmem_read !== 1'b1 || pmem_write !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL iread_fields: addr=%h rd=%b wr=%b, expected 0060 1 0", pmem_address, pmem_read, pmem_write);
        end
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            seen = mem_resp_0;
            stray |= mem_resp_1;
        end
        vectors++;
        if (!seen || cyc != 3) begin
            miscompares++;
            $display("[TB] FAIL iread_latency: resp after %0d cycles (seen=%b), expected 3", cyc, seen);
        end
        exp = q0.pop_front();
        vectors++;
        if (mem_rdata_0 !== exp || pmem_read !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL iread_data: rdata0=%h pmem_read=%b, expected %h 0", mem_rdata_0, pmem_read, exp);
        end
        mem_read_0 = 1'b0;
        tick();
        vectors++;
        if (mem_resp_0 !== 1'b0 || stray || mem_resp_1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL iread_pulse: resp0=%b resp1_seen=%b, expected 0 0", mem_resp_0, stray);
        end
    endtask

    task automatic test_dwrite();
        int          cyc = 0;
        bit          seen = 1'b0;
        bit          moved = 1'b0;
        logic [15:0] exp;
        resp_lat = 4;
        mem_write_1 = 1'b1;
        mem_address_1 = 16'h8000;
        mem_wdata_1 = 16'hBEEF;
        mem_byte_enable_1 = 2'b10;
        q1.push_back(model_rdata1);
        tick();
        vectors++;
        if ({pmem_write, pmem_read, pmem_address, pmem_wdata, pmem_byte_enable} !== {2'b10, 16'h8000, 16'hBEEF, 2'b10}) begin
            miscompares++;
            $display("[TB] FAIL dwrite_fields: wr=%b rd=%b addr=%h wd=%h be=%b, expected 1 0 8000 BEEF 10",
                     pmem_write, pmem_read, pmem_address, pmem_wdata, pmem_byte_enable);
        end
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            seen = mem_resp_1;
            if (!seen && {pmem_write, pmem_address, pmem_wdata, pmem_byte_enable} !== {1'b1, 16'h8000, 16'hBEEF, 2'b10}) moved = 1'b1;
        end
        vectors++;
        if (!seen || moved) begin
            miscompares++;
            $display("[TB] FAIL dwrite_hold: resp_seen=%b fields_moved=%b, expected 1 0", seen, moved);
        end
        exp = q1.pop_front();
        vectors++;
        if (mem_rdata_1 !== exp || mem_resp_0 !== 1'b0 || pmem_write !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dwrite_resp: rdata1=%h resp0=%b pmem_write=%b, expected %h 0 0", mem_rdata_1, mem_resp_0, pmem_write, exp);
        end
        mem_write_1 = 1'b0;
        tick();
        vectors++;
        if (mem_resp_1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dwrite_pulse: resp1=%b, expected 0", mem_resp_1);
        end
    endtask

    task automatic test_held_request();
        int          cyc = 0;
        int          extra = 0;
        int          txn_before;
        bit          seen = 1'b0;
        logic [15:0] exp;
        resp_lat = 2;
        txn_before = txn_count;
        mem_read_0 = 1'b1;
        mem_address_0 = 16'h0400;
        q0.push_back(rd_fn(16'h0400));
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            seen = mem_resp_0;
        end
        exp = q0.pop_front();
        vectors++;
        if (!seen || mem_rdata_0 !== exp) begin
            miscompares++;
            $display("[TB] FAIL held_data: seen=%b rdata0=%h, expected 1 %h", seen, mem_rdata_0, exp);
        end
        tick();
        mem_read_0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (mem_resp_0) extra++;
            tick();
        end
        vectors++;
        if (txn_count - txn_before != 1 || extra != 0 || pmem_read !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL held_single_txn: txns=%0d extra_resp=%0d, expected 1 0", txn_count - txn_before, extra);
        end
    endtask

    task automatic test_tie();
        int          cyc;
        bit          seen;
        logic [15:0] exp;
        do_reset();
        resp_lat = 2;
        mem_read_0 = 1'b1; mem_address_0 = 16'h0200;
        mem_read_1 = 1'b1; mem_address_1 = 16'h9000;
        q0.push_back(rd_fn(16'h0200));
        q1.push_back(rd_fn(16'h9000));
        tick();
        vectors++;
        if (pmem_address !== 16'h9000 || f_pmem_address !== 16'h9000) begin
            miscompares++;
            $display("[TB] FAIL tie_first: fair=%h fixed=%h, expected 9000 9000", pmem_address, f_pmem_address);
        end
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin tick(); cyc++; seen = mem_resp_1; end
        exp = q1.pop_front();
        vectors++;
        if (!seen || mem_rdata_1 !== exp) begin
            miscompares++;
            $display("[TB] FAIL tie_d_data: seen=%b rdata1=%h, expected 1 %h", seen, mem_rdata_1, exp);
        end
        model_rdata1 = exp;
        mem_read_1 = 1'b0;
        tick();
        mem_read_1 = 1'b1; mem_address_1 = 16'h9002;
        q1.push_back(rd_fn(16'h9002));
        tick();
        vectors++;
        if (pmem_address !== 16'h0200 || f_pmem_address !== 16'h9002) begin
            miscompares++;
            $display("[TB] FAIL tie_second: fair=%h fixed=%h, expected 0200 9002", pmem_address, f_pmem_address);
        end
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin tick(); cyc++; seen = mem_resp_0; end
        exp = q0.pop_front();
        vectors++;
        if (!seen || mem_rdata_0 !== exp) begin
            miscompares++;
            $display("[TB] FAIL tie_i_data: seen=%b rdata0=%h, expected 1 %h", seen, mem_rdata_0, exp);
        end
        mem_read_0 = 1'b0;
        tick();
        mem_read_0 = 1'b1; mem_address_0 = 16'h0202;
        q0.push_back(rd_fn(16'h0202));
        tick();
        vectors++;
        if (pmem_address !== 16'h9002 || f_pmem_address !== 16'h9002) begin
            miscompares++;
            $display("[TB] FAIL tie_third: fair=%h fixed=%h, expected 9002 9002", pmem_address, f_pmem_address);
        end
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin tick(); cyc++; seen = mem_resp_1; end
        exp = q1.pop_front();
        vectors++;
        if (!seen || mem_rdata_1 !== exp) begin
            miscompares++;
            $display("[TB] FAIL tie_d2_data: seen=%b rdata1=%h, expected 1 %h", seen, mem_rdata_1, exp);
        end
        model_rdata1 = exp;
        mem_read_1 = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin tick(); cyc++; seen = mem_resp_0; end
        exp = q0.pop_front();
        vectors++;
        if (!seen || mem_rdata_0 !== exp) begin
            miscompares++;
            $display("[TB] FAIL tie_i2_data: seen=%b rdata0=%h, expected 1 %h", seen, mem_rdata_0, exp);
        end
        mem_read_0 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_busy();
        int          cyc = 0;
        bit          seen = 1'b0;
        bit          stray = 1'b0;
        logic [15:0] exp;
        auto_en = 1'b0;
        mem_write_1 = 1'b1; mem_address_1 = 16'h8004;
        mem_wdata_1 = 16'h1357; mem_byte_enable_1 = 2'b01;
        tick();
        vectors++;
        if (pmem_write !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL abort_start: pmem_write=%b, expected 1", pmem_write);
        end
        tick();
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (pmem_write !== 1'b0 || pmem_address !== 16'h0 || pmem_byte_enable !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL abort_async: wr=%b addr=%h be=%b, expected 0 0000 00 before any edge", pmem_write, pmem_address, pmem_byte_enable);
        end
        mem_write_1 = 1'b0;
        #2 rst = 1'b0;
        model_rdata1 = '0;
        tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        stray = mem_resp_1 | mem_resp_0;
        tick();
        stray |= mem_resp_1 | mem_resp_0;
        vectors++;
        if (stray || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_late_resp: resp_seen=%b rd=%b wr=%b, expected 0 0 0", stray, pmem_read, pmem_write);
        end
        auto_en = 1'b1;
        resp_lat = 1;
        mem_read_0 = 1'b1; mem_address_0 = 16'h0300;
        q0.push_back(rd_fn(16'h0300));
        tick();
        vectors++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h0300) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: rd=%b addr=%h, expected 1 0300 on first edge", pmem_read, pmem_address);
        end
        while (!seen && cyc < 20) begin tick(); cyc++; seen = mem_resp_0; end
        exp = q0.pop_front();
        vectors++;
        if (!seen || mem_rdata_0 !== exp) begin
            miscompares++;
            $display("[TB] FAIL abort_recover: seen=%b rdata0=%h, expected 1 %h", seen, mem_rdata_0, exp);
        end
        mem_read_0 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_stress();
        do_reset();
        stress_mode = 1'b1;
        lat_random = 1'b1;
        fork
            begin
                for (int k = 0; k < 500; k++) begin
                    int          cyc = 0;
                    bit          seen = 1'b0;
                    logic [15:0] exp;
                    logic [15:0] a;
                    repeat ($urandom_range(0, 3)) tick();
                    a = {1'b0, 15'($urandom)};
                    cur_addr0 = a & 16'hFFFE;
                    mem_address_0 = a;
                    mem_read_0 = 1'b1;
                    q0.push_back(rd_fn(cur_addr0));
                    while (!seen && cyc < 40) begin tick(); cyc++; seen = mem_resp_0; end
                    exp = q0.pop_front();
                    vectors++;
                    if (!seen || mem_rdata_0 !== exp) begin
                        miscompares++;
                        $display("[TB] FAIL stress_port0: seen=%b rdata0=%h, expected 1 %h (addr %h)", seen, mem_rdata_0, exp, cur_addr0);
                    end
                    mem_read_0 = 1'b0;
                end
            end
            begin
                for (int k = 0; k < 500; k++) begin
                    int          cyc = 0;
                    bit          seen = 1'b0;
                    logic [15:0] exp;
                    logic [15:0] a;
                    repeat ($urandom_range(0, 3)) tick();
                    a = {1'b1, 15'($urandom)};
                    cur_addr1 = a & 16'hFFFE;
                    cur_write1 = 1'($urandom);
                    cur_wdata1 = 16'($urandom);
                    cur_be1 = 2'($urandom);
                    mem_address_1 = a;
                    mem_wdata_1 = cur_wdata1;
                    mem_byte_enable_1 = cur_be1;
                    mem_write_1 = cur_write1;
                    mem_read_1 = !cur_write1;
                    q1.push_back(cur_write1 ? model_rdata1 : rd_fn(cur_addr1));
                    while (!seen && cyc < 40) begin tick(); cyc++; seen = mem_resp_1; end
                    exp = q1.pop_front();
                    vectors++;
                    if (!seen || mem_rdata_1 !== exp) begin
                        miscompares++;
                        $display("[TB] FAIL stress_port1: seen=%b rdata1=%h, expected 1 %h (addr %h write %b)", seen, mem_rdata_1, exp, cur_addr1, cur_write1);
                    end
                    model_rdata1 = exp;
                    mem_read_1 = 1'b0;
                    mem_write_1 = 1'b0;
                end
            end
        join
        repeat (3) tick();
        stress_mode = 1'b0;
        lat_random = 1'b0;
        vectors++;
        if (q0.size() != 0 || q1.size() != 0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stress_drain: q0=%0d q1=%0d rd=%b wr=%b, expected 0 0 0 0", q0.size(), q1.size(), pmem_read, pmem_write);
        end
    endtask

    initial begin
        rst = 1'b0;
        mem_read_0 = 1'b0; mem_address_0 = '0;
        mem_read_1 = 1'b0; mem_write_1 = 1'b0; mem_byte_enable_1 = '0;
        mem_address_1 = '0; mem_wdata_1 = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        model_rdata1 = '0;
        fork
            responder();
            begin
                #5ms;
                $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
                $fatal(1, "[TB] watchdog expired");
            end
        join_none
        test_reset();
        test_single_iread();
        test_dwrite();
        test_held_request();
        test_tie();
        test_reset_mid_busy();
        test_stress();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
